vram_port: RTL and testbench

Single-port video RAM responder serving the display processor's scan-out fetches and a CPU-side command stream. It sits between the VDP (which presents a 16-bit byte address and expects the byte back), the CPU bus (write and read commands), and a synchronous single-port RAM. VDP fetches always win arbitration. CPU commands are buffered in a small FIFO and executed in the free slots.

---
 rtl/vram_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 46 ++++
 rtl/vram_port.sv | 101 ++++++++++
 tb/tb_vram_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the VRAM port: command payload and memory-slot ownership tag.
package vram_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    TAG_IDLE = 2'd0,
    TAG_VDP  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is visible combinationally.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && !o_empty_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wdata;
  end

  assign o_head_c  = r_mem[r_rd_ptr[IDX_W-1:0]];
  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
endmodule

// File: rtl/vram_port.sv
// Single-port VRAM arbiter: VDP scan-out fetches take priority, queued CPU
// commands fill the remaining slots, idle slots re-read the VDP address.
module vram_port
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vdp_addr,
  output logic [DATA_W-1:0] vdp_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  cmd_t              w_cmd_in;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_vdp_pend;
  logic              w_cpu_slot;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_refresh;
  tag_e              r_tag;

  always_comb begin
    w_cmd_in.we    = cmd_we;
    w_cmd_in.addr  = cmd_addr;
    w_cmd_in.wdata = cmd_wdata;
  end

  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_vdp_pend = r_refresh || (vdp_addr != r_last_addr);
  assign w_cpu_slot = !w_vdp_pend && !w_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wdata   (w_cmd_in),
    .i_pop     (w_cpu_slot),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Slot issue: one RAM access per clock, owner recorded for the return path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_addr <= '0;
      r_refresh   <= 1'b1;
      r_tag       <= TAG_IDLE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_vdp_pend) begin
        mem_addr    <= vdp_addr;
        r_tag       <= TAG_VDP;
        r_last_addr <= vdp_addr;
        r_refresh   <= 1'b0;
      end else if (w_cpu_slot) begin
        mem_addr <= w_head.addr;
        mem_we   <= w_head.we;
        if (w_head.we) mem_wdata <= w_head.wdata;
        // Writes return nothing, so only reads claim the return path.
        r_tag <= w_head.we ? TAG_IDLE : TAG_CPU;
      end else begin
        mem_addr <= vdp_addr;
        r_tag    <= TAG_IDLE;
      end
    end
  end

  // Return path: capture RAM data one clock after issue according to the tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      vdp_data <= '0;
      rd_data  <= '0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= (r_tag == TAG_CPU);
      if (r_tag == TAG_VDP) vdp_data <= mem_rdata;
      if (r_tag == TAG_CPU) rd_data  <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vram_port.sv
// Directed-plus-random bench for vram_port with a RAM model and an in-order
// command scoreboard kept as a flat memory image.
module tb_vram_port;
  import vram_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] vdp_addr = 16'h0123;
  logic [DATA_W-1:0] vdp_data;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  vram_port #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .vdp_addr  (vdp_addr),
    .vdp_data  (vdp_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return (a == 12'h123) ? 8'hA5 : 8'(a * 7 + 3);
  endfunction

  // RAM model: 4K words, CPU traffic in 0x000-0x7FF, VDP traffic in 0x800-0xFFF.
  logic [7:0] ram [0:4095];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(12'(i));
      ram_ready <= 1'b1;
    end else if (mem_we === 1'b1) begin
      ram[mem_addr[11:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr[11:0]];

  logic [23:0] obs_wr[$];
  logic [7:0]  obs_rd[$];
  int          obs_rd_cyc[$];
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_wr.push_back({mem_addr, mem_wdata});
    if (rd_done === 1'b1) begin
      obs_rd.push_back(rd_data);
      obs_rd_cyc.push_back(cyc);
    end
  end

  logic [7:0]  ref_mem [0:4095];
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commands execute in arrival order, so a read sees every earlier write.
  function automatic void model_accept(input logic we, input logic [15:0] a, input logic [7:0] d);
    if (we) begin
      ref_mem[a[11:0]] = d;
      exp_wr.push_back({a, d});
    end else begin
      exp_rd.push_back(ref_mem[a[11:0]]);
    end
  endfunction

  task automatic send(input logic we, input logic [15:0] a, input logic [7:0] d, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    for (int k = 0; k < 20 && !done; k++) begin
      if (cmd_ready === 1'b1) done = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (done) begin
      acc = cyc;
      model_accept(we, a, d);
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (obs_wr.size() < exp_wr.size() || obs_rd.size() < exp_rd.size()); k++)
      tick();
    repeat (3) tick();
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    chk({tag, "_nrd"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      chk({tag, "_wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
      chk({tag, "_rd"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
    obs_wr.delete(); obs_rd.delete(); obs_rd_cyc.delete();
    exp_wr.delete(); exp_rd.delete();
  endtask

  function automatic logic [15:0] next_vdp(input logic [15:0] cur, input int step);
    return 16'h8800 | 16'(11'(cur[10:0] + 11'(step)));
  endfunction

  initial begin
    int acc;
    int n_acc;
    int n_iss;
    bit acc_now;
    bit found;
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic [23:0] cmds[$];

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

    // Reset values, then the first post-reset fetch.
    tick(); tick();
    chk("rst_vdp_data", 32'(vdp_data), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_done", 32'(rd_done), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    reset = 1'b0;
    tick();
    chk("fetch_addr", 32'(mem_addr), 32'h0123);
    chk("fetch_we", 32'(mem_we), 32'h0);
    chk("vdp_early", 32'(vdp_data), 32'h0);
    tick();
    chk("vdp_first", 32'(vdp_data), 32'hA5);
    chk("rd_done_idle", 32'(rd_done), 32'h0);

    // Write then read the same address.
    send(1'b1, 16'h0040, 8'h3C, acc);
    send(1'b0, 16'h0040, 8'h00, acc);
    chk("wr_pulse_we", 32'(mem_we), 32'h1);
    chk("wr_pulse_addr", 32'(mem_addr), 32'h0040);
    drain();
    chk("rd_latency", 32'((obs_rd_cyc.size() > 0) ? obs_rd_cyc[0] : -1), 32'(acc + 2));
    chk("rd_hold", 32'(rd_data), 32'h3C);
    check_events("wr_rd");

    // Twenty back-to-back writes while the VDP address moves every 8 clocks.
    for (int i = 0; i < 20; i++)
      cmds.push_back({16'($urandom_range(0, 16'h07FF)), 8'($urandom)});
    n_acc = 0; n_iss = 0;
    for (int k = 0; k < 40; k++) begin
      acc_now = 1'b0;
      if (k % 8 == 0) vdp_addr = next_vdp(vdp_addr, int'($urandom_range(1, 255)));
      if (cmds.size() > 0) begin
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_addr = cmds[0][23:8]; cmd_wdata = cmds[0][7:0];
        acc_now = (cmd_ready === 1'b1);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (acc_now) begin
        model_accept(1'b1, cmds[0][23:8], cmds[0][7:0]);
        void'(cmds.pop_front());
        n_acc++;
      end
      if (mem_we === 1'b1) n_iss++;
      chk("stream_ready", 32'(cmd_ready), 32'((n_acc - n_iss) < int'(DEPTH)));
      if (k % 8 == 0) chk("stream_vdp_issue", 32'(mem_addr), 32'(vdp_addr));
      if (k % 8 == 1) chk("stream_vdp_data", 32'(vdp_data), 32'(ref_mem[vdp_addr[11:0]]));
    end
    cmd_valid = 1'b0;
    chk("stream_all_sent", 32'(cmds.size()), 32'h0);
    drain();
    check_events("stream");

    // VDP change on the clock a read reaches the head delays rd_done by one.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0040; cmd_wdata = 8'h00;
    chk("delay_ready", 32'(cmd_ready), 32'h1);
    tick();
    acc = cyc;
    model_accept(1'b0, 16'h0040, 8'h00);
    cmd_valid = 1'b0;
    vdp_addr = next_vdp(vdp_addr, 77);
    tick();
    chk("delay_vdp_first", 32'(mem_addr), 32'(vdp_addr));
    tick();
    chk("delay_cpu_second", 32'(mem_addr), 32'h0040);
    tick();
    chk("delay_rd_done", 32'(rd_done), 32'h1);
    chk("delay_rd_data", 32'(rd_data), 32'h3C);
    tick();
    chk("delay_rd_pulse", 32'(rd_done), 32'h0);
    chk("delay_vdp_data", 32'(vdp_data), 32'(ref_mem[vdp_addr[11:0]]));
    chk("delay_latency", 32'((obs_rd_cyc.size() > 0) ? obs_rd_cyc[0] : -1), 32'(acc + 3));
    check_events("delay");

    // Fill the FIFO behind VDP fetches, then reset while the head read is in flight.
    for (int k = 0; k < 4; k++) begin
      vdp_addr = next_vdp(vdp_addr, 1);
      cmd_valid = 1'b1; cmd_we = (k != 0);
      cmd_addr = 16'h0200 + 16'(k); cmd_wdata = 8'($urandom);
      chk("fill_ready", 32'(cmd_ready), 32'h1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_ready", 32'(cmd_ready), 32'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (mem_addr === 16'h0200 && mem_we === 1'b0) found = 1'b1;
    end
    chk("rst_read_issued", 32'(found), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", 32'(cmd_ready), 32'h1);
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    chk("mid_rst_rd_done", 32'(rd_done), 32'h0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'h0);
    tick();
    chk("refetch_addr", 32'(mem_addr), 32'(vdp_addr));
    tick();
    chk("refetch_data", 32'(vdp_data), 32'(ref_mem[vdp_addr[11:0]]));
    repeat (4) tick();
    for (int k = 1; k < 4; k++)
      chk("flushed_write", 32'(ram[12'h200 + 12'(k)]), 32'(ref_mem[12'h200 + 12'(k)]));
    check_events("reset");

    // Two entries queued, then simultaneous push/pop across three pointer rounds.
    n_acc = 0; n_iss = 0;
    for (int k = 0; k < 26; k++) begin
      if (k < 2) vdp_addr = next_vdp(vdp_addr, 3);
      we = 1'($urandom_range(0, 1));
      a  = 16'h0300 + 16'($urandom_range(0, 7));
      d  = 8'($urandom);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      acc_now = (cmd_ready === 1'b1);
      tick();
      if (acc_now) begin
        model_accept(we, a, d);
        n_acc++;
      end
      if (mem_addr[15] === 1'b0) n_iss++;
      if (k >= 2) chk("wrap_occupancy", 32'(n_acc - n_iss), 32'd2);
      chk("wrap_ready", 32'(cmd_ready), 32'h1);
    end
    cmd_valid = 1'b0;
    drain();
    check_events("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
